// File: rtl/counter_monitor_if.sv
// Bundle between an observed up/down counter and its sequence checker.
// Handshake note: there is no valid/ready pair here; every signal is sampled
// on every rising clk edge, so "valid" is implicitly always 1 and the monitor
// can never stall the counter (ready is implicitly always 1 as well).
interface counter_monitor_if #(
  parameter int n     = 4,
  parameter int ERR_W = 8
);
  // Observed counter controls and output
  logic         en;
  logic         count_up;
  logic         load;
  logic [n-1:0] set;
  logic [n-1:0] count;
  // Monitor control
  logic         clr;
  // Monitor status
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             fault;
  logic [n-1:0]     expected;

  // Side that drives the counter signals and reads status
  modport master (
    output en, count_up, load, set, count, clr,
    input  locked, err, err_cnt, fault, expected
  );

  // The monitor itself
  modport slave (
    input  en, count_up, load, set, count, clr,
    output locked, err, err_cnt, fault, expected
  );
endinterface

// File: rtl/counter_monitor.sv
// In-circuit sequence checker for an up/down counter: predicts each next
// count from the previous sample and flags mismatches (pulse, saturating
// count, sticky fault after a run of consecutive mismatches).
module counter_monitor #(
  parameter int n         = 4,
  parameter int ERR_W     = 8,
  parameter int FAULT_LIM = 3
) (
  input  logic              clk,
  input  logic              res_n,
  counter_monitor_if.slave  mon,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [n-1:0]     CNT_ONE = {{(n-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [n-1:0]     p_count_q, p_set_q;
  logic             p_en_q, p_up_q, p_load_q;
  logic [7:0]       run_q, run_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [n-1:0]     expected_q, expected_d;
  logic             locked_q, locked_d;
  logic [n-1:0]     exp_v;
  logic             mismatch;
  logic             comparing;
  logic             trip;

  // Prediction from the previous sample; load beats enable, arithmetic wraps mod 2^n
  always_comb begin
    exp_v = p_count_q;
    if (p_load_q) begin
      exp_v = p_set_q;
    end else if (p_en_q) begin
      exp_v = p_up_q ? (p_count_q + CNT_ONE) : (p_count_q - CNT_ONE);
    end
  end

  // Case inequality so an X/Z count reads as a mismatch in simulation
  assign mismatch  = (mon.count !== exp_v);
  assign comparing = (state_q != SYNC);
  assign trip      = mismatch && ((int'(run_q) + 1) == FAULT_LIM);

  // FSM state register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: clr always returns to SYNC, FAULT is left only by clr/reset
  always_comb begin
    state_d = state_q;
    if (mon.clr) begin
      state_d = SYNC;
    end else begin
      case (state_q)
        SYNC:    state_d = TRACK;
        TRACK:   if (trip) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = SYNC;
      endcase
    end
  end

  // Compare datapath next values: error pulse, saturating counters, last prediction
  always_comb begin
    run_d      = run_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    expected_d = expected_q;
    locked_d   = (state_q == TRACK) && (state_d == TRACK);
    if (mon.clr) begin
      run_d     = '0;
      err_cnt_d = '0;
    end else if (comparing) begin
      expected_d = exp_v;
      if (mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_ONE;
        if (run_q != '1)     run_d     = run_q + 8'd1;
      end else begin
        run_d = '0;
      end
    end
  end

  // Sample registers (always re-synced to the observed count) and compare results
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      p_count_q  <= '0;
      p_set_q    <= '0;
      p_en_q     <= 1'b0;
      p_up_q     <= 1'b0;
      p_load_q   <= 1'b0;
      run_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      expected_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      p_count_q  <= mon.count;
      p_set_q    <= mon.set;
      p_en_q     <= mon.en;
      p_up_q     <= mon.count_up;
      p_load_q   <= mon.load;
      run_q      <= run_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      expected_q <= expected_d;
      locked_q   <= locked_d;
    end
  end

  // FSM outputs, all taken straight from registers
  always_comb begin
    mon.locked   = locked_q;
    mon.fault    = (state_q == FAULT);
    mon.err      = err_q;
    mon.err_cnt  = err_cnt_q;
    mon.expected = expected_q;
    state_o      = state_q;
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a behavioural counter model drives the
// monitor, with optional overrides of the counter value to inject faults.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       res_n;
  logic [1:0] st_main, st_sat;
  logic [3:0] ctr_v;
  int         total = 0;
  int         bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  counter_monitor_if #(.n(4), .ERR_W(8)) mif ();
  counter_monitor_if #(.n(4), .ERR_W(2)) sif ();

  assign sif.en       = mif.en;
  assign sif.count_up = mif.count_up;
  assign sif.load     = mif.load;
  assign sif.set      = mif.set;
  assign sif.count    = mif.count;
  assign sif.clr      = mif.clr;

  counter_monitor #(.n(4), .ERR_W(8), .FAULT_LIM(3)) dut (
    .clk(clk), .res_n(res_n), .mon(mif.slave), .state_o(st_main)
  );

  counter_monitor #(.n(4), .ERR_W(2), .FAULT_LIM(3)) dut_sat (
    .clk(clk), .res_n(res_n), .mon(sif.slave), .state_o(st_sat)
  );

  // driver: one clock of counter activity; called and returns at a negedge.
  // frc overrides the counter's own value (the counter really jumps there).
  task automatic step(input logic e, input logic up, input logic ld,
                      input logic [3:0] sv, input logic frc,
                      input logic [3:0] fv, input logic cl);
    logic [3:0] c;
    c = frc ? fv : ctr_v;
    mif.en = e; mif.count_up = up; mif.load = ld;
    mif.set = sv; mif.count = c; mif.clr = cl;
    @(posedge clk);
    if (ld)     ctr_v = sv;
    else if (e) ctr_v = up ? (c + 4'd1) : (c - 4'd1);
    else        ctr_v = c;
    @(negedge clk);
  endtask

  task automatic up_step();
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n = 1'b0;
    ctr_v = 4'd0;
    mif.en = 1'b0; mif.count_up = 1'b0; mif.load = 1'b0;
    mif.set = 4'd0; mif.count = 4'd0; mif.clr = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    res_n = 1'b0;
    mif.en = 1'b0; mif.count_up = 1'b0; mif.load = 1'b0;
    mif.set = 4'd0; mif.count = 4'd0; mif.clr = 1'b0;
    ctr_v = 4'd0;
    repeat (2) @(negedge clk);
    total++; if (mif.locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", mif.locked); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", mif.err); end
    total++; if (mif.err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt got=%0d want=0", mif.err_cnt); end
    total++; if (mif.fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want=0", mif.fault); end
    total++; if (mif.expected !== 4'd0) begin bad++; $display("FAIL rst_expected got=%0d want=0", mif.expected); end
    total++; if (st_main !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", st_main); end
    res_n = 1'b1;
  endtask

  task automatic test_clean_count();
    logic [3:0] w;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      w = 4'(i);
      up_step();
      total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL clean_err[%0d] got=%b want=0", i, mif.err); end
      total++; if (mif.locked !== (i >= 1)) begin bad++; $display("FAIL clean_locked[%0d] got=%b want=%b", i, mif.locked, (i >= 1)); end
      if (i >= 1) begin
        total++; if (mif.expected !== w) begin bad++; $display("FAIL clean_expected[%0d] got=%0d want=%0d", i, mif.expected, w); end
      end
    end
    total++; if (mif.err_cnt !== 8'd0) begin bad++; $display("FAIL clean_err_cnt got=%0d want=0", mif.err_cnt); end
    total++; if (mif.expected !== 4'd1) begin bad++; $display("FAIL clean_final_expected got=%0d want=1", mif.expected); end
  endtask

  task automatic test_down_load_hold();
    logic [3:0] dn_tab [5];
    dn_tab = '{4'd0, 4'd15, 4'd14, 4'd13, 4'd12};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL down_err[%0d] got=%b want=0", i, mif.err); end
      if (i >= 1) begin
        total++; if (mif.expected !== dn_tab[i]) begin bad++; $display("FAIL down_expected[%0d] got=%0d want=%0d", i, mif.expected, dn_tab[i]); end
      end
    end
    // load with enable also high: load must win
    step(1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0);
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL load_err got=%b want=0", mif.err); end
    total++; if (mif.expected !== 4'd11) begin bad++; $display("FAIL load_expected got=%0d want=11", mif.expected); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL hold_err[%0d] got=%b want=0", i, mif.err); end
      total++; if (mif.expected !== 4'd15) begin bad++; $display("FAIL hold_expected[%0d] got=%0d want=15", i, mif.expected); end
    end
    total++; if (mif.err_cnt !== 8'd0) begin bad++; $display("FAIL hold_err_cnt got=%0d want=0", mif.err_cnt); end
  endtask

  task automatic test_single_glitch();
    do_reset();
    repeat (5) up_step();
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0);
    total++; if (mif.err !== 1'b1) begin bad++; $display("FAIL glitch_err got=%b want=1", mif.err); end
    total++; if (mif.err_cnt !== 8'd1) begin bad++; $display("FAIL glitch_err_cnt got=%0d want=1", mif.err_cnt); end
    total++; if (mif.fault !== 1'b0) begin bad++; $display("FAIL glitch_fault got=%b want=0", mif.fault); end
    total++; if (mif.expected !== 4'd5) begin bad++; $display("FAIL glitch_expected got=%0d want=5", mif.expected); end
    for (int i = 0; i < 4; i++) begin
      up_step();
      total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL glitch_after_err[%0d] got=%b want=0", i, mif.err); end
      total++; if (mif.err_cnt !== 8'd1) begin bad++; $display("FAIL glitch_after_cnt[%0d] got=%0d want=1", i, mif.err_cnt); end
      total++; if (mif.locked !== 1'b1) begin bad++; $display("FAIL glitch_after_locked[%0d] got=%b want=1", i, mif.locked); end
    end
  endtask

  task automatic test_fault_trip();
    do_reset();
    repeat (4) up_step();
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
      total++; if (mif.err !== 1'b1) begin bad++; $display("FAIL trip_err[%0d] got=%b want=1", k, mif.err); end
      total++; if (mif.err_cnt !== 8'(k)) begin bad++; $display("FAIL trip_err_cnt[%0d] got=%0d want=%0d", k, mif.err_cnt, k); end
      total++; if (mif.fault !== (k == 3)) begin bad++; $display("FAIL trip_fault[%0d] got=%b want=%b", k, mif.fault, (k == 3)); end
      total++; if (mif.locked !== (k < 3)) begin bad++; $display("FAIL trip_locked[%0d] got=%b want=%b", k, mif.locked, (k < 3)); end
    end
    // compares continue while in FAULT
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
    total++; if (mif.err_cnt !== 8'd4) begin bad++; $display("FAIL fault_err_cnt got=%0d want=4", mif.err_cnt); end
    total++; if (st_main !== 2'd2) begin bad++; $display("FAIL fault_state got=%0d want=2", st_main); end
    total++; if (mif.fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b want=1", mif.fault); end
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    total++; if (mif.err_cnt !== 8'd0) begin bad++; $display("FAIL clr_err_cnt got=%0d want=0", mif.err_cnt); end
    total++; if (mif.fault !== 1'b0) begin bad++; $display("FAIL clr_fault got=%b want=0", mif.fault); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", mif.err); end
    total++; if (st_main !== 2'd0) begin bad++; $display("FAIL clr_state got=%0d want=0", st_main); end
    up_step();
    total++; if (mif.locked !== 1'b0) begin bad++; $display("FAIL clr_locked1 got=%b want=0", mif.locked); end
    up_step();
    total++; if (mif.locked !== 1'b1) begin bad++; $display("FAIL clr_locked2 got=%b want=1", mif.locked); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL clr_resume_err got=%b want=0", mif.err); end
  endtask

  task automatic test_saturation();
    logic [1:0] sat_tab [5];
    int pulses;
    sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pulses = 0;
    do_reset();
    repeat (2) up_step();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, ctr_v + 4'd5, 1'b0);
      if (sif.err === 1'b1) pulses++;
      total++; if (sif.err_cnt !== sat_tab[k]) begin bad++; $display("FAIL sat_err_cnt[%0d] got=%0d want=%0d", k, sif.err_cnt, sat_tab[k]); end
      up_step();
      if (sif.err === 1'b1) pulses++;
    end
    total++; if (pulses != 5) begin bad++; $display("FAIL sat_pulses got=%0d want=5", pulses); end
    total++; if (mif.err_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide_cnt got=%0d want=5", mif.err_cnt); end
  endtask

  task automatic test_x_count();
    do_reset();
    repeat (2) up_step();
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'bxxxx, 1'b0);
    total++; if (mif.err !== 1'b1) begin bad++; $display("FAIL xcount_err got=%b want=1", mif.err); end
    total++; if (mif.err_cnt !== 8'd1) begin bad++; $display("FAIL xcount_err_cnt got=%0d want=1", mif.err_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    up_step();
    up_step();
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
    up_step();
    total++; if (mif.err_cnt !== 8'd1) begin bad++; $display("FAIL mid_pre_cnt got=%0d want=1", mif.err_cnt); end
    total++; if (mif.expected !== 4'd6) begin bad++; $display("FAIL mid_pre_expected got=%0d want=6", mif.expected); end
    mif.count = ctr_v;
    res_n = 1'b0;
    #1;
    total++; if (mif.err_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", mif.err_cnt); end
    total++; if (mif.expected !== 4'd0) begin bad++; $display("FAIL mid_rst_expected got=%0d want=0", mif.expected); end
    total++; if (mif.locked !== 1'b0) begin bad++; $display("FAIL mid_rst_locked got=%b want=0", mif.locked); end
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    up_step();
    total++; if (mif.locked !== 1'b0) begin bad++; $display("FAIL mid_sync_locked got=%b want=0", mif.locked); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL mid_sync_err got=%b want=0", mif.err); end
    up_step();
    total++; if (mif.locked !== 1'b1) begin bad++; $display("FAIL mid_resume_locked got=%b want=1", mif.locked); end
    total++; if (mif.err !== 1'b0) begin bad++; $display("FAIL mid_resume_err got=%b want=0", mif.err); end
    total++; if (mif.expected !== 4'd8) begin bad++; $display("FAIL mid_resume_expected got=%0d want=8", mif.expected); end
    up_step();
    total++; if (mif.err_cnt !== 8'd0) begin bad++; $display("FAIL mid_resume_cnt got=%0d want=0", mif.err_cnt); end
  endtask

  // run all scenarios, then report
  initial begin
    res_n = 1'b0;
    test_reset();
    test_clean_count();
    test_down_load_hold();
    test_single_glitch();
    test_fault_trip();
    test_saturation();
    test_x_count();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // runaway guard
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
